// File: rtl/bdu_scheduler.sv
// Batch scheduler for an array of bit-serial distance units: loads reference
// batches, streams query/reference bits MSB first, waits for the units, then drains.
module bdu_scheduler #(
    parameter int NUM_BDU = 4,
    parameter int B       = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [B-1:0]           query,
    input  logic                   ref_valid,
    input  logic [NUM_BDU*B-1:0]   ref_data,
    input  logic                   ref_last,
    output logic                   ref_ready,
    output logic [NUM_BDU-1:0]     lane_valid,
    output logic [NUM_BDU-1:0]     lane_q_bit,
    output logic [NUM_BDU-1:0]     lane_r_bit,
    output logic [$clog2(B)-1:0]   bit_idx,
    input  logic [NUM_BDU-1:0]     lane_done,
    output logic                   out_valid,
    output logic [15:0]            batch_count,
    output logic                   busy,
    output logic                   query_done
);

    localparam int BW = $clog2(B);
    localparam int DW = (NUM_BDU > 1) ? $clog2(NUM_BDU) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        WAIT,
        DRAIN
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BW-1:0]        bit_cnt;
    logic [DW-1:0]        drain_cnt;
    logic [B-1:0]         query_q;
    logic [NUM_BDU*B-1:0] ref_q;
    logic                 last_q;
    logic                 done_q;
    logic [15:0]          batch_q;
    logic                 drain_end;
    logic                 all_done;
    logic [NUM_BDU-1:0]   r_bits;

    assign drain_end   = (drain_cnt == DW'(NUM_BDU - 1));
    assign all_done    = &lane_done;
    assign busy        = (state != IDLE);
    assign query_done  = done_q;
    assign batch_count = batch_q;

    for (genvar i = 0; i < NUM_BDU; i++) begin : g_lane
        logic [B-1:0] word;
        assign word      = ref_q[i*B +: B];
        assign r_bits[i] = word[bit_cnt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        ref_ready  = 1'b0;
        lane_valid = '0;
        lane_q_bit = '0;
        lane_r_bit = '0;
        bit_idx    = '0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                ref_ready = 1'b1;
                if (ref_valid) state_next = STREAM;
            end
            STREAM: begin
                lane_valid = '1;
                lane_q_bit = {NUM_BDU{query_q[bit_cnt]}};
                lane_r_bit = r_bits;
                bit_idx    = bit_cnt;
                if (bit_cnt == '0) state_next = WAIT;
            end
            WAIT: begin
                if (all_done) state_next = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (drain_end) state_next = last_q ? IDLE : LOAD;
            end
            default: state_next = IDLE;
        endcase
    end

    // query_done is registered so it lands on the first IDLE cycle, after batch_count has updated
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            drain_cnt <= '0;
            query_q   <= '0;
            ref_q     <= '0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            batch_q   <= '0;
        end else begin
            done_q <= (state == DRAIN) && drain_end && last_q;
            case (state)
                IDLE: begin
                    if (start) begin
                        query_q <= query;
                        batch_q <= '0;
                    end
                end
                LOAD: begin
                    if (ref_valid) begin
                        ref_q   <= ref_data;
                        last_q  <= ref_last;
                        bit_cnt <= BW'(B - 1);
                    end
                end
                STREAM: begin
                    if (bit_cnt != '0) bit_cnt <= bit_cnt - BW'(1);
                end
                WAIT: begin
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    if (drain_end) begin
                        if (batch_q != 16'hFFFF) batch_q <= batch_q + 16'd1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
